// File: rtl/spi_defs_pkg.sv
// Shared definitions for the SPI master controller: FSM state encodings,
// frame geometry and a helper that builds the outgoing 16-bit frame word.
package spi_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int   FRAME_BITS = 16;
  localparam logic RW_READ    = 1'b1;

  // Byte0 = {addr, rw}; byte1 = write data, or zeros for a read so MOSI
  // idles low while the slave returns its data byte.
  function automatic logic [15:0] frame_word(input logic [6:0] a,
                                             input logic       r,
                                             input logic [7:0] d);
    logic [7:0] data_byte;
    if (r == RW_READ) begin
      data_byte = 8'h00;
    end else begin
      data_byte = d;
    end
    return {a, r, data_byte};
  endfunction

endpackage

// File: rtl/spi_clk_divider.sv
// SCLK timing generator. While enabled it runs a counter over one full SCLK
// bit period (low half first, then high half) and flags the last clk of
// each half so the controller can drive registered SCLK/MOSI edges.
module spi_clk_divider #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic lo_last,
  output logic hi_last
);

  localparam int DIV_W = $clog2(HALF_PERIOD) + 1;
  localparam logic [DIV_W-1:0] LO_LAST_CNT = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] HI_LAST_CNT = DIV_W'(2 * HALF_PERIOD - 1);

  logic [DIV_W-1:0] div_cnt_r;

  // Bit-period counter: held at zero while disabled, wraps after the high half.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= '0;
    end else if (!en) begin
      div_cnt_r <= '0;
    end else if (div_cnt_r == HI_LAST_CNT) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign lo_last = en && (div_cnt_r == LO_LAST_CNT);
  assign hi_last = en && (div_cnt_r == HI_LAST_CNT);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: turns a one-cycle parallel request into one 16-bit
// SPI frame (mode 0, MSB first) and returns the read byte captured on MISO.
// All pin outputs are registered so they are glitch-free at the board.
module spi_master_ctrl
  import spi_defs::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [3:0]       LAST_BIT   = 4'(FRAME_BITS - 1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [15:0]      shreg_r;
  logic             rw_q_r;
  logic [7:0]       rx_r;
  logic             div_en_s;
  logic             lo_last_s;
  logic             hi_last_s;

  assign div_en_s = (state_r == ST_SHIFT);

  spi_clk_divider #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .en      (div_en_s),
    .lo_last (lo_last_s),
    .hi_last (hi_last_s)
  );

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE, driving the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_cnt_r <= 4'd0;
      shreg_r   <= 16'h0000;
      rw_q_r    <= 1'b0;
      rx_r      <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'h00;
      sclk_pin  <= 1'b0;
      cs_pin    <= 1'b1;
      mosi_pin  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            shreg_r  <= frame_word(addr, rw, wdata);
            rw_q_r   <= rw;
            mosi_pin <= addr[6];
            cs_pin   <= 1'b0;
            busy     <= 1'b1;
            cnt_r    <= '0;
            state_r  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_r == SETUP_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_SHIFT;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SHIFT: begin
          if (lo_last_s) begin
            sclk_pin <= 1'b1;
          end
          if (hi_last_s) begin
            // End of a bit: SCLK falls and MOSI moves on together, so MOSI
            // only ever changes at the start of a low half.
            sclk_pin <= 1'b0;
            if ((rw_q_r == RW_READ) && bit_cnt_r[3]) begin
              rx_r <= {rx_r[6:0], miso_pin};
            end
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= 4'd0;
              mosi_pin  <= 1'b0;
              state_r   <= ST_HOLD;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              shreg_r   <= {shreg_r[14:0], 1'b0};
              mosi_pin  <= shreg_r[14];
            end
          end
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            cnt_r   <= '0;
            cs_pin  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_IDLE;
            if (rw_q_r == RW_READ) begin
              rdata <= rx_r;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= '0;
          busy     <= 1'b0;
          sclk_pin <= 1'b0;
          cs_pin   <= 1'b1;
          mosi_pin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a behavioural mode-0 SPI memory slave captures
// each frame and answers reads; directed vectors plus corner-case sequences.
module tb_spi_master_ctrl;

  localparam int LATENCY = 137;   // 1 + 4 + 32*4 + 4 with default parameters

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       miso_pin = 1'b0;

  int errors = 0;
  int checks = 0;

  spi_master_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .sclk_pin (sclk_pin),
    .cs_pin   (cs_pin),
    .mosi_pin (mosi_pin),
    .miso_pin (miso_pin)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural SPI memory slave ----------------
  logic [7:0]  mem [128];
  logic [15:0] sl_rx = 16'h0000;
  logic [15:0] last_frame = 16'h0000;
  logic [7:0]  sl_tx = 8'h00;
  int          sl_bits = 0;
  int          frames_cnt = 0;
  int          rise_cnt = 0;

  // Capture MOSI on SCLK rise; CS rising abandons any partial frame.
  always @(posedge sclk_pin or posedge cs_pin) begin
    if (cs_pin) begin
      sl_bits = 0;
    end else begin
      rise_cnt++;
      sl_rx = {sl_rx[14:0], mosi_pin};
      sl_bits++;
      if (sl_bits == 8 && sl_rx[0]) sl_tx = mem[sl_rx[7:1]];
      if (sl_bits == 16) begin
        last_frame = sl_rx;
        frames_cnt++;
        if (!sl_rx[8]) mem[sl_rx[15:9]] = sl_rx[7:0];
        sl_bits = 0;
      end
    end
  end

  // Drive MISO on SCLK fall, MSB of the read byte after the 8th rise.
  always @(negedge sclk_pin) begin
    if (!cs_pin && sl_bits >= 8 && sl_bits <= 15) miso_pin = sl_tx[15 - sl_bits];
    else miso_pin = 1'b0;
  end

  // ---------------- monitors ----------------
  int   done_cnt = 0;
  int   mosi_viol = 0;
  logic prev_mosi = 1'b0;
  logic prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (!cs_pin && sclk_pin && prev_sclk && (mosi_pin !== prev_mosi)) mosi_viol++;
    prev_mosi = mosi_pin;
    prev_sclk = sclk_pin;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request for one clk edge, then scramble the don't-care inputs.
  task automatic start_req(input logic r, input logic [6:0] a, input logic [7:0] d);
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
  endtask

  // Count cycles from the start cycle (0) until done is seen, bounded.
  task automatic wait_done(output int lat);
    bit ok;
    ok = 1'b0;
    lat = 1;
    for (int i = 0; i < 1000; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [15:0] frame;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, lat2, f0, r0, d0;

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h55] = 8'hC3;

    vecs[0] = '{1'b0, 7'h15, 8'hA5, 16'h2AA5, 8'h00};
    vecs[1] = '{1'b1, 7'h15, 8'h00, 16'h2B00, 8'hA5};
    vecs[2] = '{1'b0, 7'h7F, 8'h3C, 16'hFE3C, 8'hA5};
    vecs[3] = '{1'b1, 7'h7F, 8'hEE, 16'hFF00, 8'h3C};
    vecs[4] = '{1'b1, 7'h55, 8'h00, 16'hAB00, 8'hC3};
    vecs[5] = '{1'b0, 7'h00, 8'hFF, 16'h00FF, 8'hC3};
    vecs[6] = '{1'b1, 7'h00, 8'h00, 16'h0100, 8'hFF};
    vecs[7] = '{1'b0, 7'h40, 8'h81, 16'h8081, 8'hFF};
    vecs[8] = '{1'b1, 7'h40, 8'h00, 16'h8100, 8'h81};

    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", 32'(cs_pin), 32'd1);
    chk("rst_sclk", 32'(sclk_pin), 32'd0);
    chk("rst_mosi", 32'(mosi_pin), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset while SCLK is high in the middle of a read frame.
    f0 = frames_cnt; r0 = rise_cnt; d0 = done_cnt;
    start_req(1'b1, 7'h15, 8'h00);
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 300 && !(rise_cnt >= r0 + 3 && sclk_pin); i++) begin
      @(posedge clk); #1;
    end
    chk("abort_sclk_high", 32'(sclk_pin), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_cs", 32'(cs_pin), 32'd1);
    chk("abort_sclk", 32'(sclk_pin), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_frame", 32'(frames_cnt - f0), 32'd0);

    // Directed frames.
    foreach (vecs[k]) begin
      f0 = frames_cnt; r0 = rise_cnt;
      start_req(vecs[k].rw, vecs[k].addr, vecs[k].wdata);
      wait_done(lat);
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(LATENCY));
      chk($sformatf("v%0d_rdata", k), 32'(rdata), 32'(vecs[k].rdata));
      chk($sformatf("v%0d_cs_done", k), 32'(cs_pin), 32'd1);
      chk($sformatf("v%0d_busy_done", k), 32'(busy), 32'd0);
      chk($sformatf("v%0d_frames", k), 32'(frames_cnt - f0), 32'd1);
      chk($sformatf("v%0d_frame", k), 32'(last_frame), 32'(vecs[k].frame));
      chk($sformatf("v%0d_rises", k), 32'(rise_cnt - r0), 32'd16);
      repeat (2) @(posedge clk);
      #1;
    end

    // Start pulses while busy are ignored.
    f0 = frames_cnt; r0 = rise_cnt; d0 = done_cnt;
    start_req(1'b0, 7'h2A, 8'h99);
    start = 1'b1; rw = 1'b1; addr = 7'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    start = 1'b1; rw = 1'b0; addr = 7'h02; wdata = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    repeat (150) @(posedge clk);
    #1;
    chk("busy_ign_frames", 32'(frames_cnt - f0), 32'd1);
    chk("busy_ign_rises", 32'(rise_cnt - r0), 32'd16);
    chk("busy_ign_dones", 32'(done_cnt - d0), 32'd1);
    chk("busy_ign_frame", 32'(last_frame), 32'h5499);
    chk("busy_ign_idle", 32'(busy), 32'd0);

    // Back-to-back: second request presented in the done cycle.
    start_req(1'b0, 7'h33, 8'h5C);
    wait_done(lat);
    chk("b2b_lat1", 32'(lat), 32'(LATENCY));
    chk("b2b_frame1", 32'(last_frame), 32'h665C);
    start_req(1'b1, 7'h33, 8'h00);
    chk("b2b_cs_low", 32'(cs_pin), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat2);
    chk("b2b_lat2", 32'(lat2), 32'(LATENCY));
    chk("b2b_frame2", 32'(last_frame), 32'h6700);
    chk("b2b_rdata", 32'(rdata), 32'h5C);

    chk("mosi_stable_high", 32'(mosi_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
